step3: RTL
==========

STEP3 -- requirements
Module: step3

Interface
REQ-001 SHALL have parameter N_ACTION, default 3, number of actions.
REQ-002 SHALL have parameter N_POINT, default 16, number of belief points.
REQ-003 SHALL have parameter N_STATE, default 2, number of states.
REQ-004 SHALL have parameter DATA_W, default 16, unsigned Q0.16 element width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port en_step3, input, 1 bit: start request, level, from the step2 stage.
REQ-009 SHALL have port gamma_action_bilief, input, [N_ACTION][N_POINT][N_STATE] x DATA_W: per-action candidate alpha vectors.
REQ-010 SHALL have port point_belief, input, [N_POINT][N_STATE] x DATA_W: belief points.
REQ-011 SHALL have port alpha_new, output, [N_POINT][N_STATE] x DATA_W: winning alpha vector per point.
REQ-012 SHALL have port best_action, output, [N_POINT] x 2 bits: winning action index per point.
REQ-013 SHALL have port best_value, output, [N_POINT] x (2*DATA_W+1): winning dot product per point.
REQ-014 SHALL have port busy, output, 1 bit: high in LOAD and CALC.
REQ-015 SHALL have port en_step4, output, 1 bit: one-cycle done pulse.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, CALC, DONE.
REQ-017 SHALL transition IDLE->LOAD on a clock edge with en_step3=1; en_step3 is ignored in every other state.
REQ-018 SHALL, in LOAD (1 cycle), latch gamma_action_bilief and point_belief into internal buffers, clear point index p and action index a, then go to CALC.
REQ-019 SHALL, in CALC, evaluate one (p,a) pair per cycle, a inner (0..N_ACTION-1), p outer (0..N_POINT-1): 48 cycles at default parameters.
REQ-020 SHALL compute value = sum over s of belief[p][s]*gamma[a][p][s]: unsigned, 2*DATA_W-bit products, (2*DATA_W+1)-bit sum, no truncation or saturation.
REQ-021 SHALL keep a running best per point; the candidate replaces it only if strictly greater, so ties keep the lowest action index; a=0 always loads.
REQ-022 SHALL, on the edge ending the evaluation of (p, N_ACTION-1), write alpha_new[p], best_action[p] and best_value[p]; all other entries hold.
REQ-023 SHALL go CALC->DONE after (N_POINT-1, N_ACTION-1); DONE lasts 1 cycle with en_step4=1, then goes to IDLE.
REQ-024 SHALL restart from IDLE on the next edge if en_step3 is still high (level semantics); the start-to-en_step4 latency is 1+1+48 = 50 edges.
REQ-025 SHALL hold outputs stable between runs; input changes after LOAD SHALL NOT affect the run.

Reset
REQ-026 SHALL, on asserted rst regardless of state, go to IDLE and clear all outputs, buffers and indices to 0 (busy=0, en_step4=0).
REQ-027 SHALL abandon a run interrupted by reset mid-CALC with no en_step4 pulse and no partial results retained.

Structure
REQ-028 SHALL take N_ACTION, N_POINT, N_STATE, DATA_W and the typedefs belief_t, alpha_t and value_t from shared package pomdp_pkg.
REQ-029 SHALL implement the dot product in a combinational sub-module step3_dot (N_STATE multipliers plus adder tree), instantiated once.

Verification
REQ-030 SHALL verify gamma[0]={1,0}, gamma[1]={0,0}, gamma[2]={0,1} scaled as 0x0001 per element: with point_belief[i]={i*0x1000, 0xffff-i*0x1000}, the values compare as belief[0] vs belief[1].
REQ-031 SHALL verify gamma[0][*]={0xffff,0}, gamma[1][*]={0,0}, gamma[2][*]={0,0xffff} with the REQ-030 beliefs -> best_action = 2 for points 0..7 and 0 for points 8..15; en_step4 on edge 50 after start; alpha_new matches the chosen gamma row.
REQ-032 SHALL verify all gamma = 0 -> best_action = 0 for every point, best_value = 0, alpha_new = 0 (tie rule).
REQ-033 SHALL verify all gamma = 0xffff and all belief = 0xffff -> best_value = 0x1FFFC0002 for every point (no overflow).
REQ-034 SHALL verify that pulsing en_step3 during CALC changes nothing and gives a single en_step4, and that changing inputs after LOAD does not alter results.
REQ-035 SHALL verify that rst asserted at CALC cycle 20 -> busy=0 and all outputs 0 immediately, no en_step4, and a clean run after release.

Source files
------------

// File: rtl/pomdp_pkg.sv
// ============================================================
// pomdp_pkg : shared sizes and types for the POMDP value-iteration stages
// Rev 1.0
// ============================================================
`default_nettype none

package pomdp_pkg;

    localparam int N_ACTION = 3;
    localparam int N_POINT  = 16;
    localparam int N_STATE  = 2;
    localparam int DATA_W   = 16;

    typedef logic [N_STATE-1:0][DATA_W-1:0] belief_t;
    typedef logic [N_STATE-1:0][DATA_W-1:0] alpha_t;
    typedef logic [2*DATA_W:0]              value_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } step3_state_t;

endpackage

`default_nettype wire

// File: rtl/step3_dot.sv
// ============================================================
// step3_dot : unsigned belief . alpha dot product, full precision
// Rev 1.0
// ============================================================
`default_nettype none

module step3_dot
    import pomdp_pkg::*;
(
    input  belief_t belief_i,
    input  alpha_t  alpha_i,
    output value_t  value_o
);

    logic [N_STATE-1:0][2*DATA_W-1:0] prod;
    value_t                           sum;

    for (genvar s = 0; s < N_STATE; s++) begin : g_mul
        assign prod[s] = belief_i[s] * alpha_i[s];
    end

    always_comb begin
        sum = '0;
        for (int s = 0; s < N_STATE; s++) begin
            sum = sum + value_t'(prod[s]);
        end
    end

    assign value_o = sum;

endmodule

`default_nettype wire

// File: rtl/step3.sv
// ============================================================
// step3 : per belief point, pick the action whose alpha vector maximises
//         the dot product with the belief; ties keep the lowest action.
// Rev 1.0
// ============================================================
`default_nettype none

module step3 #(
    parameter int N_ACTION = pomdp_pkg::N_ACTION,
    parameter int N_POINT  = pomdp_pkg::N_POINT,
    parameter int N_STATE  = pomdp_pkg::N_STATE,
    parameter int DATA_W   = pomdp_pkg::DATA_W
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 en_step3,
    input  logic [N_ACTION-1:0][N_POINT-1:0][N_STATE-1:0][DATA_W-1:0] gamma_action_bilief,
    input  logic [N_POINT-1:0][N_STATE-1:0][DATA_W-1:0]          point_belief,
    output logic [N_POINT-1:0][N_STATE-1:0][DATA_W-1:0]          alpha_new,
    output logic [N_POINT-1:0][1:0]                              best_action,
    output logic [N_POINT-1:0][2*DATA_W:0]                       best_value,
    output logic                                                 busy,
    output logic                                                 en_step4
);

    import pomdp_pkg::*;

    localparam int P_W = (N_POINT > 1) ? $clog2(N_POINT) : 1;

    step3_state_t state_q, state_d;
    logic [P_W-1:0] p_q, p_d;
    logic [1:0]     a_q, a_d;

    logic [N_ACTION-1:0][N_POINT-1:0][N_STATE-1:0][DATA_W-1:0] gamma_q;
    logic [N_POINT-1:0][N_STATE-1:0][DATA_W-1:0]               belief_q;

    value_t     best_val_q,   best_val_d;
    logic [1:0] best_act_q,   best_act_d;
    alpha_t     best_alpha_q, best_alpha_d;

    alpha_t  cand_alpha;
    belief_t cand_belief;
    value_t  cand_value;
    logic    last_a, last_p, take;

    assign cand_alpha  = gamma_q[a_q][p_q];
    assign cand_belief = belief_q[p_q];
    assign last_a      = (a_q == 2'(N_ACTION-1));
    assign last_p      = (p_q == P_W'(N_POINT-1));
    // Strict compare keeps the earliest action on ties; action 0 seeds the best.
    assign take        = (a_q == 2'd0) || (cand_value > best_val_q);

    step3_dot u_dot (
        .belief_i (cand_belief),
        .alpha_i  (cand_alpha),
        .value_o  (cand_value)
    );

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        a_d          = a_q;
        best_val_d   = best_val_q;
        best_act_d   = best_act_q;
        best_alpha_d = best_alpha_q;
        case (state_q)
            ST_IDLE: begin
                if (en_step3) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                p_d     = '0;
                a_d     = '0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                if (take) begin
                    best_val_d   = cand_value;
                    best_act_d   = a_q;
                    best_alpha_d = cand_alpha;
                end
                if (last_a) begin
                    a_d = '0;
                    if (last_p) state_d = ST_DONE;
                    else        p_d     = p_q + P_W'(1);
                end else begin
                    a_d = a_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            p_q          <= '0;
            a_q          <= '0;
            best_val_q   <= '0;
            best_act_q   <= '0;
            best_alpha_q <= '0;
            gamma_q      <= '0;
            belief_q     <= '0;
            alpha_new    <= '0;
            best_action  <= '0;
            best_value   <= '0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            a_q          <= a_d;
            best_val_q   <= best_val_d;
            best_act_q   <= best_act_d;
            best_alpha_q <= best_alpha_d;
            if (state_q == ST_LOAD) begin
                gamma_q  <= gamma_action_bilief;
                belief_q <= point_belief;
            end
            if (state_q == ST_CALC && last_a) begin
                alpha_new[p_q]   <= best_alpha_d;
                best_action[p_q] <= best_act_d;
                best_value[p_q]  <= best_val_d;
            end
        end
    end

    assign busy     = (state_q == ST_LOAD) || (state_q == ST_CALC);
    assign en_step4 = (state_q == ST_DONE);

endmodule

`default_nettype wire
